enc164_seq: RTL

- Sequential 16:4 encoder; the inverse of the team's 4:16 decoder.
- Captures a 16-bit request word and emits the 4-bit index of every asserted bit, one index per accepted transfer, over a valid/ready handshake.
- Feeds the 7-segment display path: indices drive the hex digit, and `done` marks the end of the word.
- A completion pulse and a count of emitted indices close each word.

---
 rtl/enc164_seq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/enc164_seq.sv
// Sequential 16:4 encoder: captures a request word and offers the index of every set bit,
// one per valid/ready transfer. Optional abort input is enabled by defining ENC164_ABORT_EN.
module enc164_seq #(
  parameter bit HIGH_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] req,
  input  logic        codeReady,
`ifdef ENC164_ABORT_EN
  input  logic        abort,
`endif
  output logic [3:0]  code,
  output logic        codeValid,
  output logic        busy,
  output logic        done,
  output logic        emptyWord,
  output logic [4:0]  emitCount
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pending_q, pending_d;
  logic [4:0]  count_q, count_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        empty_q, empty_d;
  logic        xfer;
  logic        abort_w;

`ifdef ENC164_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Index of the next bit to offer; the loop direction makes the last hit win.
  function automatic logic [3:0] pick_index(input logic [15:0] bits);
    logic [3:0] idx;
    idx = 4'd0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 16; i++) if (bits[i]) idx = 4'(i);
    end else begin
      for (int i = 15; i >= 0; i--) if (bits[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Handshake: code is offered while codeValid=1 and held stable until a cycle with
  // codeReady=1 accepts it; codeReady is ignored whenever codeValid=0.
  assign xfer = valid_q && codeReady;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    empty_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          pending_d = req;
          count_d   = 5'd0;
          if (req != 16'd0) begin
            state_d = ST_EMIT;
          end else begin
            state_d = ST_DONE;
            empty_d = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (xfer) begin
          pending_d = pending_q & ~(16'd1 << code_q);
          count_d   = count_q + 5'd1;
        end
        if (abort_w) pending_d = 16'd0;
        if (pending_d == 16'd0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are computed from the next-state values.
    valid_d = (state_d == ST_EMIT);
    code_d  = valid_d ? pick_index(pending_d) : 4'd0;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= 16'd0;
      count_q   <= 5'd0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      empty_q   <= empty_d;
    end
  end

  assign code      = code_q;
  assign codeValid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign emptyWord = empty_q;
  assign emitCount = count_q;

endmodule
